// File: rtl/sel_mux2.sv
// Two-input WIDTH-bit selector: zero-latency combinational output plus a registered copy
// with valid, captured select and a saturating select-switch counter. Optional macro SEL_MUX2_PARITY_EN adds y_par.

module sel_mux2_lane (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);
    // Pure ternary keeps this path free of clock/reset and lets X on s propagate in simulation.
    assign y = s ? a : b;
endmodule

module sel_mux2 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    input  logic             in_vld,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             out_vld,
    output logic             sel_q,
`ifdef SEL_MUX2_PARITY_EN
    output logic [CNT_W-1:0] sw_cnt,
    output logic             y_par
`else
    output logic [CNT_W-1:0] sw_cnt
`endif
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            sel_mux2_lane u_lane (
                .a (a[gi]),
                .b (b[gi]),
                .s (s),
                .y (y[gi])
            );
        end
    endgenerate

    logic sw_hit;
    logic cnt_sat;

    // Compare against the pre-update select so the first sample after reset sees sel_q=0.
    assign sw_hit  = in_vld && (s != sel_q);
    assign cnt_sat = &sw_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q     <= '0;
            out_vld <= 1'b0;
            sel_q   <= 1'b0;
            sw_cnt  <= '0;
        end else begin
            out_vld <= in_vld;
            if (in_vld) begin
                y_q   <= y;
                sel_q <= s;
            end
            if (sw_hit && !cnt_sat)
                sw_cnt <= sw_cnt + 1'b1;
        end
    end

`ifdef SEL_MUX2_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            y_par <= 1'b0;
        else if (in_vld)
            y_par <= ^y;
    end
`endif

endmodule

// File: tb/tb_sel_mux2.sv
// Directed bench for sel_mux2: three instances cover WIDTH=1, WIDTH=8 and a CNT_W=2 counter.

module tb_sel_mux2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // WIDTH=1 instance
    logic       a1, b1, s1, v1;
    logic       y1, yq1, ov1, sq1;
    logic [7:0] cnt1;
    // WIDTH=8 instance
    logic [7:0] a8, b8, y8, yq8, cnt8;
    logic       s8, v8, ov8, sq8;
    // CNT_W=2 instance
    logic [3:0] a4, b4, y4, yq4;
    logic       s4, v4, ov4, sq4;
    logic [1:0] cnt4;
`ifdef SEL_MUX2_PARITY_EN
    logic par1, par8, par4;
`endif

    sel_mux2 #(.WIDTH(1), .CNT_W(8)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .s(s1), .in_vld(v1),
        .y(y1), .y_q(yq1), .out_vld(ov1), .sel_q(sq1),
`ifdef SEL_MUX2_PARITY_EN
        .y_par(par1),
`endif
        .sw_cnt(cnt1)
    );

    sel_mux2 #(.WIDTH(8), .CNT_W(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .s(s8), .in_vld(v8),
        .y(y8), .y_q(yq8), .out_vld(ov8), .sel_q(sq8),
`ifdef SEL_MUX2_PARITY_EN
        .y_par(par8),
`endif
        .sw_cnt(cnt8)
    );

    sel_mux2 #(.WIDTH(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .s(s4), .in_vld(v4),
        .y(y4), .y_q(yq4), .out_vld(ov4), .sel_q(sq4),
`ifdef SEL_MUX2_PARITY_EN
        .y_par(par4),
`endif
        .sw_cnt(cnt4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_sat [6];
        exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

        rst_n = 1'b0;
        a1 = 1'b1; b1 = 1'b0; s1 = 1'b1; v1 = 1'b1;
        a8 = 8'hA5; b8 = 8'h3C; s8 = 1'b1; v8 = 1'b1;
        a4 = 4'h9; b4 = 4'h6; s4 = 1'b0; v4 = 1'b1;
        #2;

        // Combinational path, no clock edge yet
        check("w1_y_a1_s1", 32'(y1), 32'd1);
        s1 = 1'b0; #1;
        check("w1_y_b0_s0", 32'(y1), 32'd0);
        a1 = 1'b0; b1 = 1'b1; #1;
        check("w1_y_b1_s0", 32'(y1), 32'd1);
        s1 = 1'b1; #1;
        check("w1_y_a0_s1", 32'(y1), 32'd0);

        // Reset held over two edges with in_vld=1
        tick();
        tick();
        check("rst_yq",     32'(yq8),  32'h00);
        check("rst_ovld",   32'(ov8),  32'd0);
        check("rst_selq",   32'(sq8),  32'd0);
        check("rst_swcnt",  32'(cnt8), 32'd0);
        check("rst_w1_yq",  32'(yq1),  32'd0);
        check("rst_y8_trk", 32'(y8),   32'hA5);
        s8 = 1'b0; #1;
        check("rst_y8_trk_b", 32'(y8), 32'h3C);
        check("rst_w1_y_trk", 32'(y1), 32'd0);

        // Registered path
        rst_n = 1'b1; s8 = 1'b1; v8 = 1'b1;
        a1 = 1'b1; s1 = 1'b1; v1 = 1'b1; v4 = 1'b0;
        tick();
        check("acc_yq",    32'(yq8),  32'hA5);
        check("acc_ovld",  32'(ov8),  32'd1);
        check("acc_selq",  32'(sq8),  32'd1);
        check("acc_swcnt", 32'(cnt8), 32'd1);
        check("acc_w1_yq", 32'(yq1),  32'd1);
        v8 = 1'b0; v1 = 1'b0; s8 = 1'b0; b8 = 8'hFF;
        #1;
        check("mid_y8_only", 32'(yq8), 32'hA5);
        tick();
        check("idle_ovld",  32'(ov8),  32'd0);
        check("idle_yq",    32'(yq8),  32'hA5);
        check("idle_selq",  32'(sq8),  32'd1);
        check("idle_swcnt", 32'(cnt8), 32'd1);

        // Reset wins over an accept on the same edge
        rst_n = 1'b0; v8 = 1'b1; s8 = 1'b1;
        tick();
        check("rva_yq",    32'(yq8),  32'h00);
        check("rva_ovld",  32'(ov8),  32'd0);
        check("rva_selq",  32'(sq8),  32'd0);
        check("rva_swcnt", 32'(cnt8), 32'd0);

        // Switch counting: s = 1,1,0,0,1
        rst_n = 1'b1; b8 = 8'h3C; v8 = 1'b1;
        s8 = 1'b1; tick(); check("sw0", 32'(cnt8), 32'd1); check("sw0_yq", 32'(yq8), 32'hA5);
        s8 = 1'b1; tick(); check("sw1", 32'(cnt8), 32'd1);
        s8 = 1'b0; tick(); check("sw2", 32'(cnt8), 32'd2); check("sw2_yq", 32'(yq8), 32'h3C);
        s8 = 1'b0; tick(); check("sw3", 32'(cnt8), 32'd2);
        s8 = 1'b1; tick(); check("sw4", 32'(cnt8), 32'd3); check("sw4_selq", 32'(sq8), 32'd1);
        v8 = 1'b0;

        // Saturation on CNT_W=2: toggle s on six accepts
        check("sat_start", 32'(cnt4), 32'd0);
        v4 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s4 = (i % 2 == 0);
            tick();
            check($sformatf("sat%0d", i), 32'(cnt4), 32'(exp_sat[i]));
        end
        check("sat_yq", 32'(yq4), 32'h6);
        v4 = 1'b0;

`ifdef SEL_MUX2_PARITY_EN
        rst_n = 1'b0; tick();
        check("par_rst", 32'(par8), 32'd0);
        rst_n = 1'b1; a8 = 8'h07; s8 = 1'b1; v8 = 1'b1;
        tick();
        check("par_07", 32'(par8), 32'd1);
        a8 = 8'h03;
        tick();
        check("par_03", 32'(par8), 32'd0);
        v8 = 1'b0; a8 = 8'h01;
        tick();
        check("par_hold", 32'(par8), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #20000;
        n_err++;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sel_mux2.md
Name: sel_mux2

Overview:
- Two-input, WIDTH-bit data selector used on debug/connection paths.
- Combinational output `y` follows the select immediately: `s`=1 passes `a`, `s`=0 passes `b`.
- A registered copy of the result, with valid and bookkeeping outputs, feeds downstream clocked logic.
- The combinational path must not depend on clock or reset, so connectivity checks can probe it with zero latency.

Parameters:
- WIDTH, 1, data width of `a`, `b`, `y`, `y_q`.
- CNT_W, 8, width of the select-switch counter `sw_cnt`.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  reset, synchronous, active-low.
- a  input  WIDTH  data input selected when `s`=1.
- b  input  WIDTH  data input selected when `s`=0.
- s  input  1  select.
- in_vld  input  1  qualifies `a`/`b`/`s` for the registered path.
- y  output  WIDTH  combinational result: `s` ? `a` : `b`.
- y_q  output  WIDTH  registered result.
- out_vld  output  1  `y_q` valid.
- sel_q  output  1  select value captured with the last accepted sample.
- sw_cnt  output  CNT_W  saturating count of accepted samples whose select differs from `sel_q`.

Behaviour:
- Combinational path: `y` = `a` when `s`==1, `y` = `b` when `s`==0, for every bit, with no clock involvement.
  - `s` = X/Z gives `y` = X in simulation; synthesis treats it as don't-care.
- Reset: on a rising `clk` edge with `rst_n`=0:
  - `y_q`=0, `out_vld`=0, `sel_q`=0, `sw_cnt`=0.
  - `y` is unaffected by reset.
- Accept: on a rising edge with `rst_n`=1 and `in_vld`=1:
  - `y_q` <= `y`
  - `sel_q` <= `s`
  - `out_vld` <= 1
  - latency is 1 cycle from sample to `y_q`.
- Idle: on a rising edge with `rst_n`=1 and `in_vld`=0:
  - `out_vld` <= 0
  - `y_q` and `sel_q` hold.
- Switch counter: on an accepted sample where `s` != `sel_q` (current, pre-update `sel_q`), `sw_cnt` increments by 1.
  - Saturates at 2^CNT_W-1; never wraps.
  - The first accepted sample after reset compares against `sel_q`=0.
- Back-to-back accepts: every cycle with `in_vld`=1 updates the outputs, so there is no bubble and no backpressure.
- Reset during operation: reset wins over `in_vld` on the same edge; all registers clear on that edge.
- Input changes between clock edges: affect only `y`. Registered outputs change only at edges.

Optional Feature:
- Macro: SEL_MUX2_PARITY_EN.
- Defined:
  - Adds output port `y_par` (1 bit) = even parity (XOR-reduce) of `y_q`, registered alongside `y_q`.
  - Reset value 0; updated only on accepted samples.
- Undefined:
  - Port `y_par` and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- WIDTH=1: `a`=1, `b`=0, `s`=1 -> `y`=1 at once. Then `s`=0 -> `y`=0 with no clock edge. Repeat with `a`=0, `b`=1 -> `y` mirrors `b` when `s`=0 and `a` when `s`=1.
- Reset: hold `rst_n`=0 for 2 edges with `in_vld`=1 -> `y_q`=0, `out_vld`=0, `sel_q`=0, `sw_cnt`=0. Meanwhile `y` still tracks `a`/`b`/`s`.
- Registered path, WIDTH=8:
  - `a`=0xA5, `b`=0x3C, `s`=1, `in_vld`=1 for one cycle -> next edge `y_q`=0xA5, `out_vld`=1, `sel_q`=1.
  - Then `in_vld`=0 -> `out_vld`=0, `y_q` holds 0xA5.
- Switch counting: accept samples with `s` = 1,1,0,0,1 after reset -> `sw_cnt` = 1,1,2,2,3.
- Saturation: CNT_W=2, toggle `s` on 6 consecutive accepted samples -> `sw_cnt` reaches 3 and stays 3.
- Reset vs accept: `rst_n`=0 and `in_vld`=1 on the same edge -> all registers cleared. With SEL_MUX2_PARITY_EN, a later accept of `y`=0x07 gives `y_par`=1.
